// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Holds the FSM state encoding, the M-extension funct3 op codes and the datapath width.
package mdu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Two's-complement negate when n is set; 0x80000000 maps onto itself.
    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: a shift-add multiply step or a restoring
// shift-subtract divide step over the {hi, lo} accumulator pair.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         is_div,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] opb,
    output logic [W-1:0] hi_n,
    output logic [W-1:0] lo_n
);

    logic [W:0] sum;
    logic [W:0] trial;
    logic [W:0] diff;

    always_comb begin
        sum   = {1'b0, hi} + {1'b0, opb};
        trial = {hi, lo[W-1]};
        diff  = trial - {1'b0, opb};
        hi_n  = hi;
        lo_n  = lo;
        if (is_div) begin
            // lo carries the dividend out and the quotient bits in; hi is the partial remainder
            if (!diff[W]) begin
                hi_n = diff[W-1:0];
                lo_n = {lo[W-2:0], 1'b1};
            end else begin
                hi_n = trial[W-1:0];
                lo_n = {lo[W-2:0], 1'b0};
            end
        end else begin
            // lo holds the unconsumed multiplier bits; the product shifts in from the top
            if (lo[0]) begin
                {hi_n, lo_n} = {sum, lo[W-1:1]};
            end else begin
                {hi_n, lo_n} = {1'b0, hi, lo[W-1:1]};
            end
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative RV32M multiply/divide controller: 32-cycle sequencing, operand sign
// handling, divide special cases, pipeline stall and the registered result.
//
// Handshake: StartE is a request sampled in IDLE; it is accepted on the rising
// edge where state=IDLE, StartE=1 and FlushE=0. StallMDU holds the pipeline from
// the accepting cycle until the op leaves MUL/DIV. DoneE is high for exactly the
// single DONE cycle, when MDUResultE is valid; there is no back-pressure on it.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StartE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            StallMDU,
    output logic            DoneE,
    output logic [XLEN-1:0] MDUResultE,
    output mdu_state_t      state_dbg
);

    mdu_state_t      state, state_n;
    logic [4:0]      cnt;
    logic [XLEN-1:0] hi, lo, opb;
    logic [XLEN-1:0] hi_n, lo_n;
    logic [1:0]      f3;
    logic            sa, sb;

    logic            start_ok;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_result;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] fin_result;

    mdu_step #(.W(XLEN)) u_step (
        .is_div (state == DIV),
        .hi     (hi),
        .lo     (lo),
        .opb    (opb),
        .hi_n   (hi_n),
        .lo_n   (lo_n)
    );

    // Operand decode and divide special cases, evaluated on the E-stage inputs
    always_comb begin
        start_ok = StartE & ~FlushE;
        if (funct3E[2]) begin
            a_signed = ~funct3E[0];
            b_signed = ~funct3E[0];
        end else begin
            a_signed = (funct3E[1:0] == 2'b01) || (funct3E[1:0] == 2'b10);
            b_signed = (funct3E[1:0] == 2'b01);
        end
        a_neg    = a_signed & SrcAE[XLEN-1];
        b_neg    = b_signed & SrcBE[XLEN-1];
        mag_a    = neg_if(a_neg, SrcAE);
        mag_b    = neg_if(b_neg, SrcBE);
        div_zero = (SrcBE == '0);
        div_ovf  = ~funct3E[0] && (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE == '1);
        special  = funct3E[2] & (div_zero | div_ovf);
        if (div_zero) begin
            special_result = funct3E[1] ? SrcAE : '1;
        end else begin
            special_result = funct3E[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Sign fix-up on the accumulator as it will stand after the final step
    always_comb begin
        prod   = {hi_n, lo_n};
        prod_s = (sa ^ sb) ? (~prod + 1'b1) : prod;
        if (state == DIV) begin
            fin_result = f3[1] ? neg_if(sa, hi_n) : neg_if(sa ^ sb, lo_n);
        end else begin
            fin_result = (f3 == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    if (!funct3E[2])  state_n = MUL;
                    else if (special) state_n = DONE;
                    else              state_n = DIV;
                end
            end
            MUL, DIV: begin
                if (cnt == 5'd0) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (FlushE) state_n = IDLE;

        StallMDU  = ((state == IDLE) && start_ok) || (state == MUL) || (state == DIV);
        DoneE     = (state == DONE);
        state_dbg = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= 5'd0;
            hi         <= '0;
            lo         <= '0;
            opb        <= '0;
            f3         <= 2'b00;
            sa         <= 1'b0;
            sb         <= 1'b0;
            MDUResultE <= '0;
        end else begin
            if ((state == IDLE) && start_ok) begin
                cnt <= 5'd31;
                hi  <= '0;
                lo  <= funct3E[2] ? mag_a : mag_b;
                opb <= funct3E[2] ? mag_b : mag_a;
                f3  <= funct3E[1:0];
                sa  <= a_neg;
                sb  <= b_neg;
            end else if ((state == MUL) || (state == DIV)) begin
                cnt <= cnt - 5'd1;
                hi  <= hi_n;
                lo  <= lo_n;
            end
            if (state_n == DONE && state != DONE) begin
                MDUResultE <= (state == IDLE) ? special_result : fin_result;
            end
        end
    end

endmodule
